riscv_irq_arbiter: RTL and testbench
====================================

Name: riscv_irq_arbiter

Overview:
Interrupt front-end that sits between the SoC interrupt sources and the exception controller's level-triggered irq_i vector.
- Latches, masks and arbitrates up to 32 sources.
- Presents exactly one interrupt line at a time, holding it until the core acknowledges that ID.
- A small register port configures the mask and edge/level mode per source, and exposes pending state.
- Guarantees the core sees one stable, single-hot request rather than raw, glitching lines.

Parameters:
NUM_IRQ, 32, number of interrupt sources (1..32); lines above NUM_IRQ tie to 0
ID_W, 5, width of interrupt ID

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
irq_src_i  in  NUM_IRQ  raw sources, already synchronous to clk
cfg_we_i  in  1  config write strobe
cfg_addr_i  in  2  register select: 0 MASK, 1 EDGE, 2 PENDING, 3 STATUS
cfg_wdata_i  in  32  write data
cfg_rdata_o  out  32  read data, combinational from cfg_addr_i
irq_o  out  32  one-hot request to exception controller irq_i
irq_id_o  out  ID_W  ID currently presented (valid when |irq_o)
irq_ack_i  in  1  core has entered handler (exception-controller ack of an IRQ cause)
irq_ack_id_i  in  ID_W  ID being acknowledged (cause[4:0])

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: all of the following are 0 and the state is IDLE.
  - Registers: MASK, EDGE, PENDING, src_q, rr_ptr, cur_id.
  - Outputs: irq_o, irq_id_o.
  - A reset asserted mid-operation aborts any presentation immediately.
- Pending:
  - EDGE[i]=1: PENDING[i] sets on (irq_src_i[i] & ~src_q[i]). It is sticky until cleared by a matching ack or by a PENDING write-1-to-clear.
  - EDGE[i]=0: PENDING[i] <= irq_src_i[i] every cycle. Ack and W1C have no lasting effect on level sources.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- Registers:
  - MASK and EDGE are plain read/write.
  - PENDING reads the register; writes are W1C.
  - STATUS is read-only: {busy, 26'b0, cur_id}, where busy=(state!=IDLE).
  - A write to STATUS is ignored.
- Eligible set: E = PENDING & MASK.
- FSM:
  - IDLE:
    - irq_o=0.
    - If |E: pick the first set bit searching upward from rr_ptr, wrapping at NUM_IRQ-1→0.
    - Register it into cur_id and go to PRESENT.
  - PRESENT:
    - irq_o = 1<<cur_id; irq_id_o = cur_id.
    - If irq_ack_i && irq_ack_id_i==cur_id:
      - clear PENDING[cur_id] if the source is edge-mode;
      - rr_ptr <= cur_id+1, wrapping to 0 at NUM_IRQ;
      - go to GAP.
    - Otherwise, withdraw to IDLE if E[cur_id]==0. This covers mask cleared, level source dropped, or W1C. irq_o is 0 from the next cycle.
    - An ack with a mismatched ID is ignored.
    - If an ack and a withdraw condition occur in the same cycle, the ack takes precedence.
  - GAP:
    - irq_o=0 for exactly one cycle, so the exception controller samples a deassertion.
    - Go to IDLE.
- Latency:
  - Source edge sampled in cycle n → PENDING set end of n → cur_id registered end of n+1 → irq_o asserted in n+2.
  - Ack in cycle m → irq_o=0 in m+1 and m+2 → earliest next presentation in m+3.
- irq_o is never multi-hot. irq_o is zero in IDLE and GAP.
- Configuration writes take effect at the clock edge. Reads return pre-write values in the write cycle.

Decomposition:
- Shared package riscv_defines:
  - IRQ_CFG_MASK=2'd0, IRQ_CFG_EDGE=2'd1, IRQ_CFG_PEND=2'd2, IRQ_CFG_STAT=2'd3
  - enum irq_arb_state_e {IRQ_IDLE, IRQ_PRESENT, IRQ_GAP}
- One sub-module, riscv_irq_rr_picker: combinational round-robin first-one finder.
  - Inputs: req[NUM_IRQ], ptr[ID_W].
  - Outputs: valid, id[ID_W].
  - Implement as a double-width vector rotate/mask or as two-pass priority encoders.

Test Plan:
- Reset, then MASK=0xFFFFFFFF, EDGE=0x1, pulse irq_src_i[0] for 1 cycle at n:
  - irq_o=0x1 and irq_id_o=0 from n+2;
  - ack id 0 → irq_o=0 for 2 cycles;
  - PENDING reads 0.
- Level sources 3 and 7 held high, MASK=0x88, rr_ptr=0:
  - ID 3 presented; ack → GAP → ID 7 presented;
  - ack 7 → ID 3 again (round-robin wrap).
- While presenting ID 5 (level), write MASK bit5=0 → irq_o=0 next cycle and state IDLE. Ack of ID 5 afterwards has no effect.
- Edge source 2 presented; ack with irq_ack_id_i=4 → ignored, irq_o stays 0x4. Then a new edge on src2 coincident with the correct ack → PENDING[2] stays 1, and ID 2 is re-presented after GAP.
- rr_ptr=31 after ack of 30, sources 31 and 0 pending → 31 presented, then 0 (wrap-around).
- Assert rst_n=0 mid-PRESENT → irq_o, MASK, PENDING and STATUS all read 0 immediately after release.

Source files
------------

// File: rtl/riscv_defines.sv
`default_nettype none
// ============================================================================
// Module      : riscv_defines (package)
// Description : Shared constants and types for the interrupt arbiter slice.
//               - Register-port address map for the configuration interface
//               - Arbiter FSM state encoding
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_defines;

    // Configuration register select values on cfg_addr_i
    localparam logic [1:0] IRQ_CFG_MASK = 2'd0;
    localparam logic [1:0] IRQ_CFG_EDGE = 2'd1;
    localparam logic [1:0] IRQ_CFG_PEND = 2'd2;
    localparam logic [1:0] IRQ_CFG_STAT = 2'd3;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_PRESENT = 2'd1,
        IRQ_GAP     = 2'd2
    } irq_arb_state_e;

endpackage
`default_nettype wire

// File: rtl/riscv_irq_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : riscv_irq_rr_picker
// Description : Combinational round-robin first-one finder.
//               Returns the lowest set request at or above ptr; if none
//               exists there, the lowest set request overall (wrap-around).
// Ports       : req   - request vector, one bit per source
//               ptr   - search start position (must be < NUM_IRQ)
//               valid - at least one request is set
//               id    - selected request index
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_irq_rr_picker #(
    parameter int NUM_IRQ = 32,
    parameter int ID_W    = 5
) (
    input  logic [NUM_IRQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               valid,
    output logic [ID_W-1:0]    id
);

    logic            w_hi_valid;
    logic [ID_W-1:0] w_hi_id;
    logic            w_lo_valid;
    logic [ID_W-1:0] w_lo_id;

    // Two priority encoders in one descending sweep: the last hit written
    // is the lowest index, both for the "at/above ptr" window and overall.
    always_comb begin
        w_hi_valid = 1'b0;
        w_hi_id    = '0;
        w_lo_valid = 1'b0;
        w_lo_id    = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_lo_valid = 1'b1;
                w_lo_id    = ID_W'(i);
                if (ID_W'(i) >= ptr) begin
                    w_hi_valid = 1'b1;
                    w_hi_id    = ID_W'(i);
                end
            end
        end
    end

    assign valid = w_lo_valid;
    assign id    = w_hi_valid ? w_hi_id : w_lo_id;

endmodule
`default_nettype wire

// File: rtl/riscv_irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : riscv_irq_arbiter
// Description : Interrupt front-end. Latches, masks and round-robin
//               arbitrates up to NUM_IRQ sources and presents one stable
//               one-hot request until the core acknowledges that ID.
// Ports       : clk, rst_n           - clock, async active-low reset
//               irq_src_i            - raw sources (synchronous to clk)
//               cfg_we_i/addr/wdata  - register write port
//               cfg_rdata_o          - combinational register read data
//               irq_o, irq_id_o      - one-hot request and its ID
//               irq_ack_i/ack_id_i   - core acknowledge and acknowledged ID
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_irq_arbiter
    import riscv_defines::*;
#(
    parameter int NUM_IRQ = 32,
    parameter int ID_W    = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_src_i,
    input  logic               cfg_we_i,
    input  logic [1:0]         cfg_addr_i,
    input  logic [31:0]        cfg_wdata_i,
    output logic [31:0]        cfg_rdata_o,
    output logic [31:0]        irq_o,
    output logic [ID_W-1:0]    irq_id_o,
    input  logic               irq_ack_i,
    input  logic [ID_W-1:0]    irq_ack_id_i
);

    localparam logic [ID_W-1:0] c_last_id = ID_W'(NUM_IRQ - 1);

    irq_arb_state_e     r_state;
    irq_arb_state_e     w_state_nxt;
    logic [NUM_IRQ-1:0] r_mask;
    logic [NUM_IRQ-1:0] r_edge;
    logic [NUM_IRQ-1:0] r_pend;
    logic [NUM_IRQ-1:0] r_src_q;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    r_cur_id;

    logic [NUM_IRQ-1:0] w_set;
    logic [NUM_IRQ-1:0] w_clr;
    logic [NUM_IRQ-1:0] w_pend_nxt;
    logic [NUM_IRQ-1:0] w_elig;
    logic [NUM_IRQ-1:0] w_cur_onehot;
    logic               w_cur_elig;
    logic               w_ack_hit;
    logic               w_pick_valid;
    logic [ID_W-1:0]    w_pick_id;
    logic [31:0]        w_status;

    // ------------------------------------------------------------------
    // Pending logic
    // ------------------------------------------------------------------
    assign w_cur_onehot = NUM_IRQ'(1) << r_cur_id;
    assign w_ack_hit    = (r_state == IRQ_PRESENT) && irq_ack_i &&
                          (irq_ack_id_i == r_cur_id);
    assign w_set        = r_edge & irq_src_i & ~r_src_q;
    assign w_clr        = ((cfg_we_i && (cfg_addr_i == IRQ_CFG_PEND)) ?
                           cfg_wdata_i[NUM_IRQ-1:0] : '0) |
                          (w_ack_hit ? w_cur_onehot : '0);
    // Edge bits: sticky with set-over-clear; level bits: follow the source.
    assign w_pend_nxt   = (r_edge & (w_set | (r_pend & ~w_clr))) |
                          (~r_edge & irq_src_i);
    assign w_elig       = r_pend & r_mask;
    assign w_cur_elig   = |(w_elig & w_cur_onehot);

    riscv_irq_rr_picker #(
        .NUM_IRQ (NUM_IRQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req   (w_elig),
        .ptr   (r_rr_ptr),
        .valid (w_pick_valid),
        .id    (w_pick_id)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IRQ_IDLE;
        else        r_state <= w_state_nxt;
    end

    // ------------------------------------------------------------------
    // FSM: next state. A matching ack wins over a simultaneous withdraw.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IRQ_IDLE:    if (w_pick_valid) w_state_nxt = IRQ_PRESENT;
            IRQ_PRESENT: begin
                if (w_ack_hit)        w_state_nxt = IRQ_GAP;
                else if (!w_cur_elig) w_state_nxt = IRQ_IDLE;
            end
            IRQ_GAP:     w_state_nxt = IRQ_IDLE;
            default:     w_state_nxt = IRQ_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs, decoded from registered state only
    // ------------------------------------------------------------------
    always_comb begin
        irq_o    = '0;
        irq_id_o = '0;
        if (r_state == IRQ_PRESENT) begin
            irq_o    = 32'(w_cur_onehot);
            irq_id_o = r_cur_id;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask   <= '0;
            r_edge   <= '0;
            r_pend   <= '0;
            r_src_q  <= '0;
            r_rr_ptr <= '0;
            r_cur_id <= '0;
        end else begin
            r_src_q <= irq_src_i;
            r_pend  <= w_pend_nxt;
            if (cfg_we_i && (cfg_addr_i == IRQ_CFG_MASK))
                r_mask <= cfg_wdata_i[NUM_IRQ-1:0];
            if (cfg_we_i && (cfg_addr_i == IRQ_CFG_EDGE))
                r_edge <= cfg_wdata_i[NUM_IRQ-1:0];
            if ((r_state == IRQ_IDLE) && w_pick_valid)
                r_cur_id <= w_pick_id;
            if (w_ack_hit)
                r_rr_ptr <= (r_cur_id == c_last_id) ? '0 : r_cur_id + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Register read port
    // ------------------------------------------------------------------
    always_comb begin
        w_status                = '0;
        w_status[31]            = (r_state != IRQ_IDLE);
        w_status[ID_W-1:0]      = r_cur_id;
        case (cfg_addr_i)
            IRQ_CFG_MASK: cfg_rdata_o = 32'(r_mask);
            IRQ_CFG_EDGE: cfg_rdata_o = 32'(r_edge);
            IRQ_CFG_PEND: cfg_rdata_o = 32'(r_pend);
            default:      cfg_rdata_o = w_status;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_riscv_irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_irq_arbiter
// Description : Self-checking bench for riscv_irq_arbiter. Stimulus tasks
//               push expected output values tagged with the cycle they are
//               due; a negedge monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_irq_arbiter;
    import riscv_defines::*;

    localparam int NUM_IRQ = 32;
    localparam int ID_W    = 5;

    logic               clk;
    logic               rst_n;
    logic [NUM_IRQ-1:0] irq_src;
    logic               cfg_we;
    logic [1:0]         cfg_addr;
    logic [31:0]        cfg_wdata;
    logic [31:0]        cfg_rdata;
    logic [31:0]        irq_o;
    logic [ID_W-1:0]    irq_id;
    logic               ack;
    logic [ID_W-1:0]    ack_id;

    riscv_irq_arbiter #(
        .NUM_IRQ (NUM_IRQ),
        .ID_W    (ID_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq_src_i    (irq_src),
        .cfg_we_i     (cfg_we),
        .cfg_addr_i   (cfg_addr),
        .cfg_wdata_i  (cfg_wdata),
        .cfg_rdata_o  (cfg_rdata),
        .irq_o        (irq_o),
        .irq_id_o     (irq_id),
        .irq_ack_i    (ack),
        .irq_ack_id_i (ack_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          kind;   // 0: irq_o, 1: irq_id_o
        string       tag;
        logic [31:0] val;
        int          due;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] rd_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic ex_irq(input string tag, input logic [31:0] val, input int due);
        exp_t e;
        e.kind = 0; e.tag = tag; e.val = val; e.due = due;
        sb.push_back(e);
    endtask

    task automatic ex_id(input string tag, input logic [31:0] val, input int due);
        exp_t e;
        e.kind = 1; e.tag = tag; e.val = val; e.due = due;
        sb.push_back(e);
    endtask

    // Compare every scoreboard entry due in the current cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                if (sb[i].kind == 0) check(sb[i].tag, irq_o, sb[i].val);
                else                 check(sb[i].tag, 32'(irq_id), sb[i].val);
                sb.delete(i);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        step(1);
        cfg_we    = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e, input string tag);
        cfg_addr = a;
        rd_q.push_back(e);
        #1;
        check(tag, cfg_rdata, rd_q.pop_front());
    endtask

    int n, m, m2, k, w, a, b, a2;

    initial begin
        rst_n     = 1'b0;
        irq_src   = '0;
        cfg_we    = 1'b0;
        cfg_addr  = IRQ_CFG_MASK;
        cfg_wdata = '0;
        ack       = 1'b0;
        ack_id    = '0;
        step(3);
        rst_n = 1'b1;
        ex_irq("rst_irq", 32'h0, cyc);
        ex_id("rst_id", 32'h0, cyc);
        rd(IRQ_CFG_MASK, 32'h0, "rst_mask");
        rd(IRQ_CFG_EDGE, 32'h0, "rst_edge");
        step(1);
        rd(IRQ_CFG_PEND, 32'h0, "rst_pend");
        rd(IRQ_CFG_STAT, 32'h0, "rst_stat");
        step(1);

        // 1: single edge pulse on source 0, latency and ack gap
        wr(IRQ_CFG_MASK, 32'hFFFF_FFFF);
        wr(IRQ_CFG_EDGE, 32'h1);
        n = cyc;
        irq_src[0] = 1'b1;
        ex_irq("t1_lat", 32'h0, n + 1);
        ex_irq("t1_on", 32'h1, n + 2);
        ex_id("t1_id", 32'd0, n + 2);
        step(1);
        irq_src[0] = 1'b0;
        step(2);
        m = cyc;
        ack = 1'b1; ack_id = 5'd0;
        ex_irq("t1_gap0", 32'h0, m + 1);
        ex_irq("t1_gap1", 32'h0, m + 2);
        ex_irq("t1_idle", 32'h0, m + 3);
        step(1);
        ack = 1'b0;
        rd(IRQ_CFG_PEND, 32'h0, "t1_pend");
        rd(IRQ_CFG_STAT, 32'h8000_0000, "t1_stat_gap");
        step(3);

        // 2: level sources 3 and 7, round robin with wrap
        wr(IRQ_CFG_EDGE, 32'h0);
        wr(IRQ_CFG_MASK, 32'h88);
        n = cyc;
        irq_src[3] = 1'b1; irq_src[7] = 1'b1;
        ex_irq("t2_first", 32'h8, n + 2);
        ex_id("t2_first_id", 32'd3, n + 2);
        step(2);
        m = cyc;
        ack = 1'b1; ack_id = 5'd3;
        ex_irq("t2_gap0", 32'h0, m + 1);
        ex_irq("t2_gap1", 32'h0, m + 2);
        ex_irq("t2_second", 32'h80, m + 3);
        ex_id("t2_second_id", 32'd7, m + 3);
        step(1);
        ack = 1'b0;
        step(2);
        m2 = cyc;
        ack = 1'b1; ack_id = 5'd7;
        ex_irq("t2_gap2", 32'h0, m2 + 1);
        ex_irq("t2_wrap", 32'h8, m2 + 3);
        ex_id("t2_wrap_id", 32'd3, m2 + 3);
        step(1);
        ack = 1'b0;
        step(2);
        k = cyc;
        irq_src[3] = 1'b0; irq_src[7] = 1'b0;
        ex_irq("t2_drop", 32'h0, k + 2);
        step(2);
        rd(IRQ_CFG_STAT, 32'h3, "t2_drop_stat");
        step(1);

        // 3: mask removal withdraws a level source, later ack is ignored
        wr(IRQ_CFG_MASK, 32'h20);
        n = cyc;
        irq_src[5] = 1'b1;
        ex_irq("t3_on", 32'h20, n + 2);
        ex_id("t3_id", 32'd5, n + 2);
        step(2);
        w = cyc;
        ex_irq("t3_withdrawn", 32'h0, w + 2);
        wr(IRQ_CFG_MASK, 32'h0);
        step(1);
        rd(IRQ_CFG_STAT, 32'h5, "t3_stat_idle");
        ack = 1'b1; ack_id = 5'd5;
        ex_irq("t3_ack_noeff0", 32'h0, w + 3);
        ex_irq("t3_ack_noeff1", 32'h0, w + 4);
        step(1);
        ack = 1'b0;
        rd(IRQ_CFG_STAT, 32'h5, "t3_stat_after_ack");
        irq_src[5] = 1'b0;
        step(2);

        // 4: wrong-ID ack ignored; new edge coincident with ack re-presents
        wr(IRQ_CFG_EDGE, 32'h4);
        wr(IRQ_CFG_MASK, 32'h4);
        n = cyc;
        irq_src[2] = 1'b1;
        ex_irq("t4_on", 32'h4, n + 2);
        ex_id("t4_id", 32'd2, n + 2);
        step(1);
        irq_src[2] = 1'b0;
        step(1);
        a = cyc;
        ack = 1'b1; ack_id = 5'd4;
        ex_irq("t4_badack0", 32'h4, a + 1);
        ex_irq("t4_badack1", 32'h4, a + 2);
        step(1);
        ack = 1'b0;
        step(1);
        b = cyc;
        irq_src[2] = 1'b1;
        ack = 1'b1; ack_id = 5'd2;
        ex_irq("t4_gap0", 32'h0, b + 1);
        ex_irq("t4_gap1", 32'h0, b + 2);
        ex_irq("t4_again", 32'h4, b + 3);
        ex_id("t4_again_id", 32'd2, b + 3);
        step(1);
        ack = 1'b0;
        irq_src[2] = 1'b0;
        rd(IRQ_CFG_PEND, 32'h4, "t4_pend_setwins");
        step(2);
        ack = 1'b1; ack_id = 5'd2;
        step(1);
        ack = 1'b0;
        rd(IRQ_CFG_PEND, 32'h0, "t4_pend_clr");
        step(2);

        // 5: pointer at 31 after ack of 30, then wrap to 0
        wr(IRQ_CFG_EDGE, 32'hC000_0001);
        wr(IRQ_CFG_MASK, 32'hC000_0001);
        n = cyc;
        irq_src[30] = 1'b1;
        ex_irq("t5_30", 32'h4000_0000, n + 2);
        ex_id("t5_30_id", 32'd30, n + 2);
        step(1);
        irq_src[30] = 1'b0;
        step(1);
        a = cyc;
        ack = 1'b1; ack_id = 5'd30;
        irq_src[31] = 1'b1; irq_src[0] = 1'b1;
        ex_irq("t5_gap", 32'h0, a + 1);
        ex_irq("t5_31", 32'h8000_0000, a + 3);
        ex_id("t5_31_id", 32'd31, a + 3);
        step(1);
        ack = 1'b0;
        irq_src[31] = 1'b0; irq_src[0] = 1'b0;
        step(2);
        a2 = cyc;
        ack = 1'b1; ack_id = 5'd31;
        ex_irq("t5_gap2", 32'h0, a2 + 2);
        ex_irq("t5_0", 32'h1, a2 + 3);
        ex_id("t5_0_id", 32'd0, a2 + 3);
        step(1);
        ack = 1'b0;
        step(3);

        // 6: asynchronous reset while presenting
        rst_n = 1'b0;
        ex_irq("t6_rst_irq", 32'h0, cyc);
        step(2);
        rst_n = 1'b1;
        ex_irq("t6_post_irq", 32'h0, cyc);
        rd(IRQ_CFG_MASK, 32'h0, "t6_mask");
        rd(IRQ_CFG_PEND, 32'h0, "t6_pend");
        step(1);
        rd(IRQ_CFG_STAT, 32'h0, "t6_stat");
        rd(IRQ_CFG_EDGE, 32'h0, "t6_edge");
        step(2);

        check("sb_leftover", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
